// File: rtl/loop_issue_scheduler.sv
// Pipelined-loop issue stage: pulses `happening` every II clocks for trip_count
// iterations, then waits DEPTH clocks for the pipeline to drain and pulses `done`.
module loop_issue_scheduler #(
    parameter int II    = 1,
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] trip_count,
    output logic        happening,
    output logic [31:0] iter,
    output logic        last,
    output logic        busy,
    output logic        done
);

    if (II < 1) begin : g_bad_ii
        $error("loop_issue_scheduler: II must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("loop_issue_scheduler: DEPTH must be >= 1");
    end

    localparam int IIW = (II > 1) ? $clog2(II) : 1;
    localparam int DW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IIW-1:0] II_RELOAD    = IIW'(II - 1);
    localparam logic [DW-1:0]  DEPTH_RELOAD = DW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t         state, state_n;
    logic [IIW-1:0] ii_cnt, ii_cnt_n;
    logic [DW-1:0]  drain_cnt, drain_cnt_n;
    logic [31:0]    trip_m1, trip_m1_n;
    logic [31:0]    iter_n, iter_inc;
    logic           happening_n, last_n, busy_n, done_n;

    // iter never exceeds trip_m1 while issuing, so the increment cannot wrap.
    assign iter_inc = iter + 32'd1;

    always_comb begin
        state_n     = state;
        ii_cnt_n    = ii_cnt;
        drain_cnt_n = drain_cnt;
        trip_m1_n   = trip_m1;
        iter_n      = iter;
        happening_n = 1'b0;
        last_n      = 1'b0;
        done_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (trip_count == 32'd0) begin
                        done_n = 1'b1;
                    end else begin
                        trip_m1_n   = trip_count - 32'd1;
                        happening_n = 1'b1;
                        iter_n      = 32'd0;
                        last_n      = (trip_count == 32'd1);
                        ii_cnt_n    = II_RELOAD;
                        if (trip_count == 32'd1) begin
                            state_n     = DRAIN;
                            drain_cnt_n = DEPTH_RELOAD;
                        end else begin
                            state_n = ISSUE;
                        end
                    end
                end
            end
            ISSUE: begin
                if (ii_cnt == '0) begin
                    iter_n      = iter_inc;
                    happening_n = 1'b1;
                    last_n      = (iter_inc == trip_m1);
                    ii_cnt_n    = II_RELOAD;
                    if (iter_inc == trip_m1) begin
                        state_n     = DRAIN;
                        drain_cnt_n = DEPTH_RELOAD;
                    end
                end else begin
                    ii_cnt_n = ii_cnt - IIW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    drain_cnt_n = drain_cnt - DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ii_cnt    <= '0;
            drain_cnt <= '0;
            trip_m1   <= '0;
            happening <= 1'b0;
            iter      <= '0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            ii_cnt    <= ii_cnt_n;
            drain_cnt <= drain_cnt_n;
            trip_m1   <= trip_m1_n;
            happening <= happening_n;
            iter      <= iter_n;
            last      <= last_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_loop_issue_scheduler.sv
// Scoreboard bench for loop_issue_scheduler across three II/DEPTH configurations.
module tb_loop_issue_scheduler;

    logic        clk;
    logic        rst_v   [3];
    logic        start_v [3];
    logic [31:0] tc_v    [3];
    logic        hap_v   [3];
    logic [31:0] iter_v  [3];
    logic        last_v  [3];
    logic        busy_v  [3];
    logic        done_v  [3];

    int ii_of [3] = '{1, 3, 4};
    int dp_of [3] = '{1, 2, 3};

    loop_issue_scheduler #(.II(1), .DEPTH(1)) u0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .trip_count(tc_v[0]),
        .happening(hap_v[0]), .iter(iter_v[0]), .last(last_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    loop_issue_scheduler #(.II(3), .DEPTH(2)) u1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .trip_count(tc_v[1]),
        .happening(hap_v[1]), .iter(iter_v[1]), .last(last_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    loop_issue_scheduler #(.II(4), .DEPTH(3)) u2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .trip_count(tc_v[2]),
        .happening(hap_v[2]), .iter(iter_v[2]), .last(last_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          cyc;
        logic [31:0] it;
        logic        lst;
    } exp_t;

    exp_t q[$];
    bit   eb [64];
    bit   ed [64];
    int   sel;
    int   tests;
    int   fails;

    task automatic clear_exp();
        q.delete();
        for (int i = 0; i < 64; i++) begin
            eb[i] = 1'b0;
            ed[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_v[sel] = 1'b1;
        @(negedge clk);
        rst_v[sel] = 1'b0;
    endtask

    // Reference model: expected pulse train, busy window and done cycle for an accepted start at cycle n.
    task automatic push_run(input int n, input logic [31:0] trip, input int lim);
        exp_t   e;
        longint t, ii, dp, dl;
        t  = trip;
        ii = ii_of[sel];
        dp = dp_of[sel];
        if (t == 0) begin
            ed[n+1] = 1'b1;
            return;
        end
        for (longint k = 0; k < t && n + 1 + k * ii < lim; k++) begin
            e.cyc = n + 1 + int'(k * ii);
            e.it  = 32'(k);
            e.lst = (k == t - 1);
            q.push_back(e);
        end
        dl = n + 1 + (t - 1) * ii + dp;
        for (longint c = n + 1; c < dl && c < 64; c++) eb[int'(c)] = 1'b1;
        if (dl < 64) ed[int'(dl)] = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b0; start_v[i] = 1'b1; tc_v[i] = 32'd5;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (hap_v[i] !== 1'b0 || iter_v[i] !== 32'd0 || last_v[i] !== 1'b0 ||
                busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset[%0d]: hap %b iter %0d last %b busy %b done %b, expected all 0",
                         i, hap_v[i], iter_v[i], last_v[i], busy_v[i], done_v[i]);
            end
        end
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
    endtask

    task automatic test_back_to_back();
        string nm = "back_to_back";
        exp_t  e;
        sel = 0; clear_exp(); do_reset();
        for (int n = 0; n < 20; n++) begin
            if (hap_v[sel]) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL %s: unexpected happening at cycle %0d", nm, n); end
                else begin
                    e = q.pop_front();
                    if (e.cyc != n || iter_v[sel] !== e.it || last_v[sel] !== e.lst) begin
                        fails++;
                        $display("FAIL %s: happening cycle %0d iter %0d last %b, expected cycle %0d iter %0d last %b",
                                 nm, n, iter_v[sel], last_v[sel], e.cyc, e.it, e.lst);
                    end
                end
            end
            tests++;
            if (busy_v[sel] !== eb[n] || done_v[sel] !== ed[n] || (!hap_v[sel] && last_v[sel] !== 1'b0)) begin
                fails++;
                $display("FAIL %s: cycle %0d busy %b done %b last %b, expected busy %b done %b",
                         nm, n, busy_v[sel], done_v[sel], last_v[sel], eb[n], ed[n]);
            end
            start_v[sel] = (n == 10); tc_v[sel] = 32'd4;
            if (n == 10) push_run(n, 32'd4, 64);
            @(negedge clk);
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL %s: %0d happenings missing, expected 0", nm, q.size()); end
    endtask

    task automatic test_ii3();
        string nm = "ii3";
        exp_t  e;
        sel = 1; clear_exp(); do_reset();
        for (int n = 0; n < 18; n++) begin
            if (hap_v[sel]) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL %s: unexpected happening at cycle %0d", nm, n); end
                else begin
                    e = q.pop_front();
                    if (e.cyc != n || iter_v[sel] !== e.it || last_v[sel] !== e.lst) begin
                        fails++;
                        $display("FAIL %s: happening cycle %0d iter %0d last %b, expected cycle %0d iter %0d last %b",
                                 nm, n, iter_v[sel], last_v[sel], e.cyc, e.it, e.lst);
                    end
                end
            end
            tests++;
            if (busy_v[sel] !== eb[n] || done_v[sel] !== ed[n] || (!hap_v[sel] && last_v[sel] !== 1'b0)) begin
                fails++;
                $display("FAIL %s: cycle %0d busy %b done %b last %b, expected busy %b done %b",
                         nm, n, busy_v[sel], done_v[sel], last_v[sel], eb[n], ed[n]);
            end
            start_v[sel] = (n == 5); tc_v[sel] = 32'd3;
            if (n == 5) push_run(n, 32'd3, 64);
            @(negedge clk);
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL %s: %0d happenings missing, expected 0", nm, q.size()); end
    endtask

    task automatic test_zero_trip();
        string nm = "zero_trip";
        exp_t  e;
        sel = 1; clear_exp(); do_reset();
        for (int n = 0; n < 10; n++) begin
            if (hap_v[sel]) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL %s: unexpected happening at cycle %0d", nm, n); end
                else begin
                    e = q.pop_front();
                    if (e.cyc != n || iter_v[sel] !== e.it || last_v[sel] !== e.lst) begin
                        fails++;
                        $display("FAIL %s: happening cycle %0d iter %0d last %b, expected cycle %0d iter %0d last %b",
                                 nm, n, iter_v[sel], last_v[sel], e.cyc, e.it, e.lst);
                    end
                end
            end
            tests++;
            if (busy_v[sel] !== eb[n] || done_v[sel] !== ed[n] || (!hap_v[sel] && last_v[sel] !== 1'b0)) begin
                fails++;
                $display("FAIL %s: cycle %0d busy %b done %b last %b, expected busy %b done %b",
                         nm, n, busy_v[sel], done_v[sel], last_v[sel], eb[n], ed[n]);
            end
            start_v[sel] = (n == 4); tc_v[sel] = 32'd0;
            if (n == 4) push_run(n, 32'd0, 64);
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        string nm = "start_while_busy";
        exp_t  e;
        sel = 1; clear_exp(); do_reset();
        for (int n = 0; n < 25; n++) begin
            if (hap_v[sel]) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL %s: unexpected happening at cycle %0d", nm, n); end
                else begin
                    e = q.pop_front();
                    if (e.cyc != n || iter_v[sel] !== e.it || last_v[sel] !== e.lst) begin
                        fails++;
                        $display("FAIL %s: happening cycle %0d iter %0d last %b, expected cycle %0d iter %0d last %b",
                                 nm, n, iter_v[sel], last_v[sel], e.cyc, e.it, e.lst);
                    end
                end
            end
            tests++;
            if (busy_v[sel] !== eb[n] || done_v[sel] !== ed[n] || (!hap_v[sel] && last_v[sel] !== 1'b0)) begin
                fails++;
                $display("FAIL %s: cycle %0d busy %b done %b last %b, expected busy %b done %b",
                         nm, n, busy_v[sel], done_v[sel], last_v[sel], eb[n], ed[n]);
            end
            // Starts at 7 and 10 arrive while busy and carry a different trip; only 5 and 14 are accepted.
            start_v[sel] = (n == 5 || n == 7 || n == 10 || n == 14);
            tc_v[sel]    = (n == 5) ? 32'd3 : (n == 14) ? 32'd2 : 32'd9;
            if (n == 5)  push_run(n, 32'd3, 64);
            if (n == 14) push_run(n, 32'd2, 64);
            @(negedge clk);
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL %s: %0d happenings missing, expected 0", nm, q.size()); end
    endtask

    task automatic test_mid_reset();
        string nm = "mid_reset";
        exp_t  e;
        sel = 1; clear_exp(); do_reset();
        for (int n = 0; n < 22; n++) begin
            if (hap_v[sel]) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL %s: unexpected happening at cycle %0d", nm, n); end
                else begin
                    e = q.pop_front();
                    if (e.cyc != n || iter_v[sel] !== e.it || last_v[sel] !== e.lst) begin
                        fails++;
                        $display("FAIL %s: happening cycle %0d iter %0d last %b, expected cycle %0d iter %0d last %b",
                                 nm, n, iter_v[sel], last_v[sel], e.cyc, e.it, e.lst);
                    end
                end
            end
            tests++;
            if (busy_v[sel] !== eb[n] || done_v[sel] !== ed[n] || (!hap_v[sel] && last_v[sel] !== 1'b0)) begin
                fails++;
                $display("FAIL %s: cycle %0d busy %b done %b last %b, expected busy %b done %b",
                         nm, n, busy_v[sel], done_v[sel], last_v[sel], eb[n], ed[n]);
            end
            if (n == 9) begin
                tests++;
                if (iter_v[sel] !== 32'd0) begin
                    fails++; $display("FAIL %s: iter after reset %0d, expected 0", nm, iter_v[sel]);
                end
            end
            rst_v[sel]   = (n == 8);
            start_v[sel] = (n == 5 || n == 9);
            tc_v[sel]    = 32'd3;
            if (n == 5) push_run(n, 32'd3, 64);
            if (n == 8) begin
                // Reset aborts the run: drop everything predicted after it.
                while (q.size() != 0 && q[$].cyc > 8) e = q.pop_back();
                for (int c = 9; c < 64; c++) begin eb[c] = 1'b0; ed[c] = 1'b0; end
            end
            if (n == 9) push_run(n, 32'd3, 64);
            @(negedge clk);
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL %s: %0d happenings missing, expected 0", nm, q.size()); end
    endtask

    task automatic test_late_trip_change();
        string nm = "late_trip_change";
        exp_t  e;
        sel = 2; clear_exp(); do_reset();
        for (int n = 0; n < 12; n++) begin
            if (hap_v[sel]) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL %s: unexpected happening at cycle %0d", nm, n); end
                else begin
                    e = q.pop_front();
                    if (e.cyc != n || iter_v[sel] !== e.it || last_v[sel] !== e.lst) begin
                        fails++;
                        $display("FAIL %s: happening cycle %0d iter %0d last %b, expected cycle %0d iter %0d last %b",
                                 nm, n, iter_v[sel], last_v[sel], e.cyc, e.it, e.lst);
                    end
                end
            end
            tests++;
            if (busy_v[sel] !== eb[n] || done_v[sel] !== ed[n] || (!hap_v[sel] && last_v[sel] !== 1'b0)) begin
                fails++;
                $display("FAIL %s: cycle %0d busy %b done %b last %b, expected busy %b done %b",
                         nm, n, busy_v[sel], done_v[sel], last_v[sel], eb[n], ed[n]);
            end
            start_v[sel] = (n == 2);
            tc_v[sel]    = (n >= 3) ? 32'd7 : 32'd1;
            if (n == 2) push_run(n, 32'd1, 64);
            @(negedge clk);
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL %s: %0d happenings missing, expected 0", nm, q.size()); end
    endtask

    task automatic test_max_trip();
        string nm = "max_trip";
        exp_t  e;
        sel = 0; clear_exp(); do_reset();
        for (int n = 0; n < 12; n++) begin
            if (hap_v[sel]) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL %s: unexpected happening at cycle %0d", nm, n); end
                else begin
                    e = q.pop_front();
                    if (e.cyc != n || iter_v[sel] !== e.it || last_v[sel] !== e.lst) begin
                        fails++;
                        $display("FAIL %s: happening cycle %0d iter %0d last %b, expected cycle %0d iter %0d last %b",
                                 nm, n, iter_v[sel], last_v[sel], e.cyc, e.it, e.lst);
                    end
                end
            end
            tests++;
            if (busy_v[sel] !== eb[n] || done_v[sel] !== ed[n] || (!hap_v[sel] && last_v[sel] !== 1'b0)) begin
                fails++;
                $display("FAIL %s: cycle %0d busy %b done %b last %b, expected busy %b done %b",
                         nm, n, busy_v[sel], done_v[sel], last_v[sel], eb[n], ed[n]);
            end
            start_v[sel] = (n == 2); tc_v[sel] = 32'hFFFF_FFFF;
            if (n == 2) push_run(n, 32'hFFFF_FFFF, 12);
            @(negedge clk);
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL %s: %0d happenings missing, expected 0", nm, q.size()); end
        do_reset();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sel   = 0;
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; tc_v[i] = 32'd0;
        end
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_ii3();
        test_zero_trip();
        test_start_ignored();
        test_mid_reset();
        test_late_trip_change();
        test_max_trip();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/loop_issue_scheduler.md
Name: loop_issue_scheduler

Overview:
- Pipelined-loop issue stage. It sits directly upstream of the count_every_ii_clks / condition_at_last_signal control builtins and feeds them.
- On a start pulse it issues one iteration pulse ("happening") every II clocks until trip_count iterations are issued.
- It then waits DEPTH clocks for the pipeline to drain and emits a one-cycle done pulse.
- It supplies the happening/last signals the loop self-transition logic consumes.

Parameters:
- II, 1, initiation interval in clocks between iteration issues; legal range >= 1.
- DEPTH, 1, pipeline drain latency in clocks from last issue to done; legal range >= 1.
- Illegal parameter values must cause an elaboration error.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch request; accepted only when busy=0.
- trip_count  input  32  number of iterations; sampled only in the accept cycle.
- happening  output  1  one-cycle pulse per issued iteration.
- iter  output  32  index of the current iteration; valid when happening=1, otherwise holds its last value.
- last  output  1  happening & (iter == latched trip_count-1).
- busy  output  1  high while issuing or draining.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: on rst=1 at a clock edge, all outputs are 0 the next cycle (happening, iter, last, busy, done) and state=IDLE. Reset mid-run aborts the loop with no done pulse. rst has priority over start.
- States:
  - IDLE: busy=0.
  - ISSUE: busy=1. Contains ii_cnt (down-counter, II-1..0), iter counter and latched trip.
  - DRAIN: busy=1. Contains drain counter (DEPTH-1..0).
- All outputs are registered; there is no combinational path from start to any output.
- Accept: start=1 while in IDLE at edge t.
  - trip_count != 0: latch trip, go to ISSUE. Iteration 0 happening at cycle t+1 with iter=0.
  - trip_count == 0: stay in IDLE. done=1 at cycle t+1 only; no happening; busy never rises.
- Issue timing: iteration k pulses at cycle t+1+k*II, for k = 0..trip-1.
  - II=1 gives back-to-back pulses.
  - iter is 32-bit unsigned, incremented only on issue, never wraps (bounded by trip).
- After the last iteration (L = trip-1), go to DRAIN. done pulses at cycle t+1+L*II+DEPTH.
- busy=1 from cycle t+1 through the cycle before done. busy=0 in the done cycle; state is IDLE in the done cycle.
- start while busy=1 is ignored entirely: no queuing, no effect on the latched trip.
- start in the done cycle is accepted normally; next iteration 0 follows at the next cycle.
- trip_count changes after the accept cycle have no effect.
- Maximum trip_count 2^32-1 is supported without overflow of internal counters.

Test Plan:
1. II=1, DEPTH=1, trip_count=4, start at cycle 10 -> happening at 11,12,13,14 with iter 0..3; last=1 only at 14; busy 11..14; done at 15 only.
2. II=3, DEPTH=2, trip_count=3, start at cycle 5 -> happening at 6,9,12 (iter 0,1,2); last at 12; busy 6..13; done at 14.
3. trip_count=0, start at cycle 4 -> done=1 at cycle 5 only; happening and busy stay 0 throughout.
4. In scenario 2, start pulsed at cycles 7 and 10 -> no change to the pulse train or done. start at cycle 14 (done cycle) with trip_count=2 -> happening at 15 (iter 0) and 18 (iter 1); done at 20.
5. In scenario 2, rst=1 at cycle 8 -> from cycle 9: busy=0, happening=0, iter=0, no done pulse. A start at cycle 9 restarts cleanly with iter 0 at cycle 10.
6. II=4, DEPTH=3, trip_count=1, start at cycle 2, trip_count driven to 7 at cycle 3 -> single happening at cycle 3 with last=1, iter=0; done at cycle 6.
